// File: rtl/vga_region_scanout.sv
// vga_region_scanout: VGA timing, linear framebuffer address and play-field/panel index select.
// Latency: oADDR/oX/oY/oFRAME_START/oLINE_START undelayed; oIDX/oHS/oVS/oBLANK_n trail oADDR by MEM_LAT+1.
// Backpressure: none, one pixel per clock. Border overlay is built in only when VGA_SCANOUT_BORDER_EN is defined.

module vga_region_scanout #(
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int SPLIT_X = 480,
  parameter int MEM_LAT = 2,     // index readers latency, valid range 1..4
`ifdef VGA_SCANOUT_BORDER_EN
  parameter logic [7:0] BORDER_IDX = 8'hFF,
`endif
  parameter int ADDR_W  = 19
) (
  input  logic              iVGA_CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] oADDR,
  output logic [10:0]       oX,
  output logic [9:0]        oY,
  output logic              oFRAME_START,
  output logic              oLINE_START,
  input  logic [7:0]        iIDX_A,
  input  logic [7:0]        iIDX_B,
  output logic [7:0]        oIDX,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  // Counter comparison constants, sized to the counters they are compared against.
  localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_C   = 11'(H_ACT);
  localparam logic [10:0] H_ALAST_C = 11'(H_ACT - 1);
  localparam logic [10:0] H_SS_C    = 11'(H_ACT + H_FP);
  localparam logic [10:0] H_SE_C    = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [10:0] H_SPLIT_C = 11'(SPLIT_X);
  localparam logic [9:0]  V_LAST_C  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_C   = 10'(V_ACT);
  localparam logic [9:0]  V_ALAST_C = 10'(V_ACT - 1);
  localparam logic [9:0]  V_SS_C    = 10'(V_ACT + V_FP);
  localparam logic [9:0]  V_SE_C    = 10'(V_ACT + V_FP + V_SYNC);

  // A split at or beyond the active width means the panel never shows.
  localparam bit SPLIT_ON = (SPLIT_X < H_ACT);

  // Per-pixel attributes that must travel alongside the memory read.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic rgn_b;
`ifdef VGA_SCANOUT_BORDER_EN
    logic brd;
`endif
  } pix_t;

`ifdef VGA_SCANOUT_BORDER_EN
  localparam pix_t PIX_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, rgn_b: 1'b0, brd: 1'b0};
`else
  localparam pix_t PIX_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, rgn_b: 1'b0};
`endif

  logic [10:0]       h_q, h_d;
  logic [9:0]        v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_wrap;
  logic              last_px;
  pix_t              cur_c;
  pix_t              dly_q [MEM_LAT];
  pix_t              tail;
  logic [7:0]        idx_q, idx_d;
  logic              hs_q, vs_q, blank_n_q;

  // Raster counters next-state: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_d        = h_q + 11'd1;
    v_d        = v_q;
    frame_wrap = 1'b0;
    if (h_q == H_LAST_C) begin
      h_d = '0;
      if (v_q == V_LAST_C) begin
        v_d        = '0;
        frame_wrap = 1'b1;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  // Current pixel attributes, decoded straight from the raster position.
  always_comb begin
    cur_c       = PIX_IDLE;
    cur_c.act   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    cur_c.hs    = !((h_q >= H_SS_C) && (h_q < H_SE_C));
    cur_c.vs    = !((v_q >= V_SS_C) && (v_q < V_SE_C));
    cur_c.rgn_b = SPLIT_ON && (h_q >= H_SPLIT_C);
`ifdef VGA_SCANOUT_BORDER_EN
    cur_c.brd   = cur_c.act &&
                  ((h_q == '0) || (h_q == H_ALAST_C) ||
                   (v_q == '0) || (v_q == V_ALAST_C) ||
                   (SPLIT_ON && (h_q == H_SPLIT_C)));
`endif
  end

  // The very last active pixel of the frame does not advance the address, so
  // the vertical blanking interval keeps showing the final framebuffer word.
  assign last_px = (h_q == H_ALAST_C) && (v_q == V_ALAST_C);

  // Address next-state: restart at frame wrap, step after active pixels, hold in blanking.
  always_comb begin
    addr_d = addr_q;
    if (frame_wrap) begin
      addr_d = '0;
    end else if (cur_c.act && !last_px) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Raster and address state registers.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
    end
  end

  // Attribute shift line matching the index readers' latency; flushed to idle on reset.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        dly_q[i] <= PIX_IDLE;
      end
    end else begin
      dly_q[0] <= cur_c;
      for (int i = 1; i < MEM_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Oldest stage lines up with the index data now arriving from memory.
  assign tail = dly_q[MEM_LAT-1];

  // Index select: source chosen by delayed region, black outside active video.
  always_comb begin
    idx_d = 8'h00;
    if (tail.act) begin
      idx_d = tail.rgn_b ? iIDX_B : iIDX_A;
`ifdef VGA_SCANOUT_BORDER_EN
      if (tail.brd) begin
        idx_d = BORDER_IDX;
      end
`endif
    end
  end

  // Output register stage: index and delayed syncs/blank leave together.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      idx_q     <= 8'h00;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      hs_q      <= tail.hs;
      vs_q      <= tail.vs;
      blank_n_q <= tail.act;
    end
  end

  // Start pulses are masked by reset so they stay low while the counters are held at 0,0.
  assign oFRAME_START = !reset && (h_q == '0) && (v_q == '0);
  assign oLINE_START  = !reset && (h_q == '0);
  assign oADDR        = addr_q;
  assign oX           = h_q;
  assign oY           = v_q;
  assign oIDX         = idx_q;
  assign oHS          = hs_q;
  assign oVS          = vs_q;
  assign oBLANK_n     = blank_n_q;

endmodule

// File: tb/tb_vga_region_scanout.sv
// tb_vga_region_scanout: randomized bench for vga_region_scanout with a reduced raster.
// Two instances: default-like latency with an in-range split, and deep latency with no panel and narrow address.
// Reference model works from a frame position counter, closed-form address and a latency queue.

module tb_vga_region_scanout;

  localparam int HA = 20, HFP = 3, HSW = 4, HBP = 5, HT = HA + HFP + HSW + HBP;
  localparam int VA = 12, VFP = 2, VSW = 2, VBP = 3, VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int SPL1 = 14, LAT1 = 2, AW1 = 8;
  localparam int SPL2 = 20, LAT2 = 4, AW2 = 6;
  localparam int W1 = AW1 + 34;
  localparam int W2 = AW2 + 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] idx_a = 8'h00;
  logic [7:0] idx_b = 8'h00;

  logic [AW1-1:0] addr1;
  logic [10:0]    x1;
  logic [9:0]     y1;
  logic           fs1, ls1, hs1, vs1, bl1;
  logic [7:0]     idx1;
  logic [AW2-1:0] addr2;
  logic [10:0]    x2;
  logic [9:0]     y2;
  logic           fs2, ls2, hs2, vs2, bl2;
  logic [7:0]     idx2;

  always #5 clk = ~clk;

  vga_region_scanout #(
    .H_ACT(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACT(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SPLIT_X(SPL1), .MEM_LAT(LAT1), .ADDR_W(AW1)
  ) dut1 (
    .iVGA_CLK(clk), .reset(rst), .oADDR(addr1), .oX(x1), .oY(y1),
    .oFRAME_START(fs1), .oLINE_START(ls1), .iIDX_A(idx_a), .iIDX_B(idx_b),
    .oIDX(idx1), .oHS(hs1), .oVS(vs1), .oBLANK_n(bl1)
  );

  vga_region_scanout #(
    .H_ACT(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACT(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SPLIT_X(SPL2), .MEM_LAT(LAT2), .ADDR_W(AW2)
  ) dut2 (
    .iVGA_CLK(clk), .reset(rst), .oADDR(addr2), .oX(x2), .oY(y2),
    .oFRAME_START(fs2), .oLINE_START(ls2), .iIDX_A(idx_a), .iIDX_B(idx_b),
    .oIDX(idx2), .oHS(hs2), .oVS(vs2), .oBLANK_n(bl2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic rb;
    logic bd;
  } pix_t;

  localparam pix_t IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, rb: 1'b0, bd: 1'b0};

  pix_t       pipe1[$];
  pix_t       pipe2[$];
  int         n = 0;             // frame position of the current cycle
  logic       prev_r = 1'b1;
  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_b = 8'h00;
  logic [7:0] m_idx1, m_idx2;
  logic       m_hs1, m_vs1, m_bl1, m_hs2, m_vs2, m_bl2;

  function automatic pix_t flags(input int pos, input int split);
    int h = pos % HT;
    int v = pos / HT;
    pix_t p;
    p.act = (h < HA) && (v < VA);
    p.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    p.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    p.rb  = (split < HA) && (h >= split);
    p.bd  = p.act && ((h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1) ||
                      ((split < HA) && (h == split)));
    return p;
  endfunction

  function automatic logic [7:0] pick(input pix_t p, input logic [7:0] a, input logic [7:0] b);
    if (!p.act) return 8'h00;
`ifdef VGA_SCANOUT_BORDER_EN
    if (p.bd) return 8'hFF;
`endif
    return p.rb ? b : a;
  endfunction

  // Address expected at a raster position: y*HA+x when active, else the last address written.
  function automatic int addr_of(input int pos, input int aw);
    int h = pos % HT;
    int v = pos / HT;
    int a;
    if ((v < VA) && (h < HA)) a = v * HA + h;
    else if (v < VA - 1)      a = (v + 1) * HA;
    else                      a = HA * VA - 1;
    return a % (1 << aw);
  endfunction

  task automatic model_edge();
    pix_t p;
    if (prev_r) begin
      n = 0;
      pipe1.delete();
      pipe2.delete();
      for (int i = 0; i < LAT1; i++) pipe1.push_back(IDLE);
      for (int i = 0; i < LAT2; i++) pipe2.push_back(IDLE);
      m_idx1 = 8'h00; m_hs1 = 1'b1; m_vs1 = 1'b1; m_bl1 = 1'b0;
      m_idx2 = 8'h00; m_hs2 = 1'b1; m_vs2 = 1'b1; m_bl2 = 1'b0;
    end else begin
      p = pipe1.pop_front();
      m_idx1 = pick(p, prev_a, prev_b); m_hs1 = p.hs; m_vs1 = p.vs; m_bl1 = p.act;
      pipe1.push_back(flags(n, SPL1));
      p = pipe2.pop_front();
      m_idx2 = pick(p, prev_a, prev_b); m_hs2 = p.hs; m_vs2 = p.vs; m_bl2 = p.act;
      pipe2.push_back(flags(n, SPL2));
      n = (n + 1) % FRAME;
    end
  endtask

  // One clock: advance model at the edge, drive new inputs, return at the sampling edge.
  task automatic tick(input logic r, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; idx_a = a; idx_b = b;
    prev_r = r; prev_a = a; prev_b = b;
    @(negedge clk);
  endtask

  task automatic rtick();
    tick(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W1-1:0] o1, e1;
    logic [W2-1:0] o2, e2;
    e1 = {{AW1{1'b0}}, 11'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    e2 = {{AW2{1'b0}}, 11'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      o1 = {addr1, x1, y1, fs1, ls1, idx1, hs1, vs1, bl1};
      o2 = {addr2, x2, y2, fs2, ls2, idx2, hs2, vs2, bl2};
      checks++;
      if (o1 !== e1) begin errors++; $display("FAIL reset_dut1 cyc %0d: got %h, expected %h", c, o1, e1); end
      checks++;
      if (o2 !== e2) begin errors++; $display("FAIL reset_dut2 cyc %0d: got %h, expected %h", c, o2, e2); end
    end
  endtask

  task automatic test_frame(input int cycles);
    logic [W1-1:0] o1, e1;
    logic [W2-1:0] o2, e2;
    for (int c = 0; c < cycles; c++) begin
      rtick();
      o1 = {addr1, x1, y1, fs1, ls1, idx1, hs1, vs1, bl1};
      e1 = {AW1'(addr_of(n, AW1)), 11'(n % HT), 10'(n / HT), (n == 0), (n % HT == 0),
            m_idx1, m_hs1, m_vs1, m_bl1};
      o2 = {addr2, x2, y2, fs2, ls2, idx2, hs2, vs2, bl2};
      e2 = {AW2'(addr_of(n, AW2)), 11'(n % HT), 10'(n / HT), (n == 0), (n % HT == 0),
            m_idx2, m_hs2, m_vs2, m_bl2};
      checks++;
      if (o1 !== e1) begin
        errors++;
        if (errors < 40) $display("FAIL frame_dut1 pos %0d: got %h, expected %h", n, o1, e1);
      end
      checks++;
      if (o2 !== e2) begin
        errors++;
        if (errors < 40) $display("FAIL frame_dut2 pos %0d: got %h, expected %h", n, o2, e2);
      end
    end
  endtask

  task automatic test_hs_timing();
    int k = 0;
    while (!ls1 && k < 2 * HT) begin rtick(); k++; end
    checks++;
    if (!ls1) begin errors++; $display("FAIL hs_line_start: no line start within %0d cycles", 2 * HT); end
    k = 0;
    while (hs1 && k < 3 * HT) begin rtick(); k++; end
    checks++;
    if (k != HA + HFP + LAT1 + 1) begin
      errors++; $display("FAIL hs_fall_offset: got %0d, expected %0d", k, HA + HFP + LAT1 + 1);
    end
    k = 0;
    while (!hs1 && k < 2 * HT) begin rtick(); k++; end
    checks++;
    if (k != HSW) begin errors++; $display("FAIL hs_low_width: got %0d, expected %0d", k, HSW); end
    k = 0;
    while (hs1 && k < 2 * HT) begin rtick(); k++; end
    checks++;
    if (k != HT - HSW) begin errors++; $display("FAIL hs_high_width: got %0d, expected %0d", k, HT - HSW); end
  endtask

  task automatic test_vs_timing();
    int k = 0;
    while (vs1 && k < FRAME + 10) begin rtick(); k++; end
    checks++;
    if ({y1, x1} !== {10'(VA + VFP), 11'(LAT1 + 1)}) begin
      errors++; $display("FAIL vs_fall_position: got y=%0d x=%0d, expected y=%0d x=%0d", y1, x1, VA + VFP, LAT1 + 1);
    end
    k = 0;
    while (!vs1 && k < FRAME + 10) begin rtick(); k++; end
    checks++;
    if (k != VSW * HT) begin errors++; $display("FAIL vs_low_width: got %0d, expected %0d", k, VSW * HT); end
    k = 0;
    while (vs1 && k < FRAME + 10) begin rtick(); k++; end
    checks++;
    if (k != FRAME - VSW * HT) begin
      errors++; $display("FAIL vs_high_width: got %0d, expected %0d", k, FRAME - VSW * HT);
    end
  endtask

  task automatic test_region_split();
    int pos, col, row, seen_a, seen_b;
    logic [7:0] e1, e2;
    seen_a = 0; seen_b = 0;
    tick(1'b0, 8'h11, 8'h22);   // output here still carries the previous random data
    for (int c = 0; c < FRAME; c++) begin
      tick(1'b0, 8'h11, 8'h22);
      pos = (n - LAT1 - 1 + FRAME) % FRAME; col = pos % HT; row = pos / HT;
      e1 = 8'h00;
      if (col < HA && row < VA) begin
        e1 = (col >= SPL1) ? 8'h22 : 8'h11;
`ifdef VGA_SCANOUT_BORDER_EN
        if (col == 0 || col == HA - 1 || row == 0 || row == VA - 1 || col == SPL1) e1 = 8'hFF;
`endif
      end
      pos = (n - LAT2 - 1 + FRAME) % FRAME; col = pos % HT; row = pos / HT;
      e2 = 8'h00;
      if (col < HA && row < VA) begin
        e2 = 8'h11;
`ifdef VGA_SCANOUT_BORDER_EN
        if (col == 0 || col == HA - 1 || row == 0 || row == VA - 1) e2 = 8'hFF;
`endif
      end
      if (idx1 === 8'h11) seen_a++;
      if (idx1 === 8'h22) seen_b++;
      checks++;
      if (idx1 !== e1) begin
        errors++;
        if (errors < 40) $display("FAIL split_dut1 pos %0d: got %h, expected %h", n, idx1, e1);
      end
      checks++;
      if (idx2 !== e2) begin
        errors++;
        if (errors < 40) $display("FAIL split_dut2 pos %0d: got %h, expected %h", n, idx2, e2);
      end
    end
    checks++;
    if (seen_a == 0 || seen_b == 0) begin
      errors++; $display("FAIL split_coverage: A pixels %0d, B pixels %0d, expected both nonzero", seen_a, seen_b);
    end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    logic [W1-1:0] o1, e1;
    logic [W2-1:0] o2, e2;
    while (!(x1 == 11'd15 && y1 == 10'd7) && k < FRAME + 10) begin rtick(); k++; end
    checks++;
    if (!(x1 == 11'd15 && y1 == 10'd7)) begin
      errors++; $display("FAIL midrst_reach: got x=%0d y=%0d, expected x=15 y=7", x1, y1);
    end
    tick(1'b1, 8'h5A, 8'hA5);
    tick(1'b1, 8'h5A, 8'hA5);
    e1 = {{AW1{1'b0}}, 11'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    e2 = {{AW2{1'b0}}, 11'd0, 10'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    o1 = {addr1, x1, y1, fs1, ls1, idx1, hs1, vs1, bl1};
    o2 = {addr2, x2, y2, fs2, ls2, idx2, hs2, vs2, bl2};
    checks++;
    if (o1 !== e1) begin errors++; $display("FAIL midrst_dut1: got %h, expected %h", o1, e1); end
    checks++;
    if (o2 !== e2) begin errors++; $display("FAIL midrst_dut2: got %h, expected %h", o2, e2); end
    rtick();
    checks++;
    if ({fs1, addr1, x1, bl1} !== {1'b1, {AW1{1'b0}}, 11'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_release_dut1: got fs=%b addr=%0d x=%0d blank_n=%b, expected 1 0 0 0", fs1, addr1, x1, bl1);
    end
    checks++;
    if ({fs2, addr2} !== {1'b1, {AW2{1'b0}}}) begin
      errors++; $display("FAIL midrst_release_dut2: got fs=%b addr=%0d, expected 1 0", fs2, addr2);
    end
    for (int i = 1; i <= LAT1 + 1; i++) begin
      rtick();
      checks++;
      if (bl1 !== (i == LAT1 + 1)) begin
        errors++; $display("FAIL midrst_blank_n step %0d: got %b, expected %b", i, bl1, (i == LAT1 + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(2 * FRAME + 50);
    test_hs_timing();
    test_vs_timing();
    test_region_split();
    test_mid_reset();
    test_frame(FRAME + 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
